fft_src_peak: RTL

- Consumes the Avalon-ST source (output) side of the FFT core: source_valid/sop/eop plus real/imag data, with source_ready backpressure.
- Counterpart to the sink-side framing generator that drives FFT input.
- Checks framing, computes the squared magnitude of each bin, and tracks the largest bin in a configurable search window.
- Reports the peak index and magnitude once per good frame, for frequency measurement downstream.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_src_peak_if.sv | 22 ++
 rtl/fft_src_peak_mag_sq.sv | 64 ++++++
 rtl/fft_src_peak.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and types: default framing sizes, core error codes and
// the source-side peak finder state encoding.
package fft_pkg;

  localparam int FFT_DW_DEF = 16;
  localparam int FFT_N_DEF  = 50000;
  localparam int FFT_IW_DEF = 16;

  localparam logic [1:0] FFT_ERR_NONE        = 2'b00;
  localparam logic [1:0] FFT_ERR_MISSING_SOP = 2'b01;
  localparam logic [1:0] FFT_ERR_MISSING_EOP = 2'b10;
  localparam logic [1:0] FFT_ERR_UNEXPECTED  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fft_state_e;

  function automatic logic fft_err_bad(input logic [1:0] code);
    return code != FFT_ERR_NONE;
  endfunction

endpackage

// File: rtl/fft_src_peak_if.sv
// Avalon-ST source-side bus of the FFT core, as seen by a downstream consumer.
interface fft_src_peak_if #(
  parameter int DW = 16
) ();
  logic                 source_valid;
  logic                 source_sop;
  logic                 source_eop;
  logic signed [DW-1:0] source_real;
  logic signed [DW-1:0] source_imag;
  logic [1:0]           source_error;
  logic                 source_ready;

  modport master (
    output source_valid, source_sop, source_eop, source_real, source_imag, source_error,
    input  source_ready
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_real, source_imag, source_error,
    output source_ready
  );
endinterface

// File: rtl/fft_src_peak_mag_sq.sv
// Two-stage squared magnitude: stage 1 squares real/imag, stage 2 sums them;
// beat valid, bin index and frame markers travel alongside.
module mag_sq #(
  parameter int DW = 16,
  parameter int IW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_v,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic [IW-1:0]        in_idx,
  input  logic                 in_win,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_v,
  output logic [2*DW-1:0]      out_mag,
  output logic [IW-1:0]        out_idx,
  output logic                 out_win,
  output logic                 out_first,
  output logic                 out_last
);
  localparam int MW = IW + 4;

  logic signed [2*DW-2:0] re_x, im_x;
  logic [2*DW-2:0]        s1_re2_q, s1_re2_d, s1_im2_q, s1_im2_d;
  logic [MW-1:0]          s1_meta_q, s1_meta_d, s2_meta_q, s2_meta_d;
  logic [2*DW-1:0]        s2_mag_q, s2_mag_d;

  // A square of a DW-bit signed value always fits in 2*DW-1 unsigned bits.
  always_comb begin
    re_x      = {{(DW-1){in_re[DW-1]}}, in_re};
    im_x      = {{(DW-1){in_im[DW-1]}}, in_im};
    s1_re2_d  = in_v ? $unsigned(re_x * re_x) : s1_re2_q;
    s1_im2_d  = in_v ? $unsigned(im_x * im_x) : s1_im2_q;
    s1_meta_d = {in_v, in_idx, in_win, in_first, in_last};
    s2_mag_d  = s1_meta_q[MW-1] ? ({1'b0, s1_re2_q} + {1'b0, s1_im2_q}) : s2_mag_q;
    s2_meta_d = s1_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_re2_q  <= '0;
      s1_im2_q  <= '0;
      s1_meta_q <= '0;
      s2_mag_q  <= '0;
      s2_meta_q <= '0;
    end else begin
      s1_re2_q  <= s1_re2_d;
      s1_im2_q  <= s1_im2_d;
      s1_meta_q <= s1_meta_d;
      s2_mag_q  <= s2_mag_d;
      s2_meta_q <= s2_meta_d;
    end
  end

  assign out_v     = s2_meta_q[MW-1];
  assign out_idx   = s2_meta_q[MW-2:3];
  assign out_win   = s2_meta_q[2];
  assign out_first = s2_meta_q[1];
  assign out_last  = s2_meta_q[0];
  assign out_mag   = s2_mag_q;

endmodule

// File: rtl/fft_src_peak.sv
// FFT source-side frame checker and windowed peak-bin finder.
// FFT_PEAK_BACKPRESSURE_EN: when defined, source_ready drops during FLUSH.
//
// state | meaning
// IDLE  | waiting for an accepted sop beat
// RUN   | collecting beats of a frame
// FLUSH | 2 cycles draining the magnitude pipeline; a sop here is queued
module fft_src_peak
  import fft_pkg::*;
#(
  parameter int DW        = FFT_DW_DEF,
  parameter int N         = FFT_N_DEF,
  parameter int IW        = FFT_IW_DEF,
  parameter int SEARCH_LO = 1,
  parameter int SEARCH_HI = 25000
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_src_peak_if.slave   src,
  output logic [IW-1:0]   peak_idx,
  output logic [2*DW-1:0] peak_mag,
  output logic            done,
  output logic            frame_err
);
  localparam logic [IW:0]   N_W  = (IW+1)'(N);
  localparam logic [IW-1:0] LO_W = IW'(SEARCH_LO);
  localparam logic [IW-1:0] HI_W = IW'(SEARCH_HI);

  fft_state_e      state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            fl_q, fl_d;
  logic            rdy_q, rdy_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic [IW-1:0]   pidx_q, pidx_d, midx_q, midx_d;
  logic [2*DW-1:0] pmag_q, pmag_d, max_q, max_d;

  logic            ready, acc, coll, bad;
  logic [IW:0]     cnt_inc;
  logic            start, inc, complete, abort, beat_err;
  logic            p_v, p_first, p_last, p_win;
  logic [IW-1:0]   p_idx;
  logic            m_v, m_first, m_last, m_win;
  logic [IW-1:0]   m_idx;
  logic [2*DW-1:0] m_mag;
  logic [2*DW-1:0] base_mag;
  logic [IW-1:0]   base_idx;

`ifdef FFT_PEAK_BACKPRESSURE_EN
  assign ready = rdy_q && (state_q != FLUSH);
`else
  assign ready = rdy_q;
`endif
  assign src.source_ready = ready;

  assign acc     = src.source_valid && ready;
  assign coll    = (state_q == RUN) || ((state_q == FLUSH) && pend_q);
  assign bad     = fft_err_bad(src.source_error);
  assign cnt_inc = {1'b0, cnt_q} + (IW+1)'(1);

  // Classify each accepted beat against the frame currently being collected.
  always_comb begin
    start    = 1'b0;
    inc      = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    beat_err = 1'b0;
    if (acc) begin
      if (bad) begin
        beat_err = 1'b1;
        abort    = coll;
      end else if (src.source_sop) begin
        beat_err = coll;
        if (src.source_eop) begin
          if (N == 1) begin
            complete = 1'b1;
          end else begin
            beat_err = 1'b1;
            abort    = coll;
          end
        end else begin
          start = 1'b1;
        end
      end else if (!coll) begin
        beat_err = 1'b1;
      end else if (src.source_eop) begin
        if (cnt_inc == N_W) begin
          complete = 1'b1;
        end else begin
          beat_err = 1'b1;
          abort    = 1'b1;
        end
      end else if (cnt_inc == N_W) begin
        beat_err = 1'b1;
        abort    = 1'b1;
      end else begin
        inc = 1'b1;
      end
    end
  end

  assign p_v     = start || inc || complete;
  assign p_idx   = src.source_sop ? '0 : cnt_q;
  assign p_first = p_v && src.source_sop;
  assign p_last  = complete;
  assign p_win   = (p_idx >= LO_W) && (p_idx <= HI_W);

  mag_sq #(.DW(DW), .IW(IW)) u_mag_sq (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_v      (p_v),
    .in_re     (src.source_real),
    .in_im     (src.source_imag),
    .in_idx    (p_idx),
    .in_win    (p_win),
    .in_first  (p_first),
    .in_last   (p_last),
    .out_v     (m_v),
    .out_mag   (m_mag),
    .out_idx   (m_idx),
    .out_win   (m_win),
    .out_first (m_first),
    .out_last  (m_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    fl_d    = fl_q;
    rdy_d   = 1'b1;
    ferr_d  = beat_err;
    if (start) begin
      cnt_d = (IW)'(1);
    end else if (inc) begin
      cnt_d = cnt_inc[IW-1:0];
    end else if (complete || abort) begin
      cnt_d = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (complete) begin
          state_d = FLUSH;
          fl_d    = 1'b0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (complete) begin
          state_d = FLUSH;
          fl_d    = 1'b0;
          pend_d  = 1'b0;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        // A frame completing while flushing simply restarts the drain.
        if (complete) begin
          fl_d   = 1'b0;
          pend_d = 1'b0;
        end else begin
          if (start) begin
            pend_d = 1'b1;
          end else if (abort) begin
            pend_d = 1'b0;
          end
          if (fl_q) begin
            state_d = pend_d ? RUN : IDLE;
            fl_d    = 1'b0;
            pend_d  = 1'b0;
          end else begin
            fl_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
        fl_d    = 1'b0;
      end
    endcase
  end

  // The sop beat of a frame reseeds the running max as it leaves the pipeline,
  // so beats of a previous frame still in flight are never mixed in.
  always_comb begin
    base_mag = m_first ? '0 : max_q;
    base_idx = m_first ? LO_W : midx_q;
    max_d    = max_q;
    midx_d   = midx_q;
    if (m_v) begin
      max_d  = base_mag;
      midx_d = base_idx;
      if (m_win && (m_mag > base_mag)) begin
        max_d  = m_mag;
        midx_d = m_idx;
      end
    end
    done_d = m_v && m_last;
    pmag_d = done_d ? max_d : pmag_q;
    pidx_d = done_d ? midx_d : pidx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      fl_q    <= 1'b0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      pidx_q  <= '0;
      pmag_q  <= '0;
      midx_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      fl_q    <= fl_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      pidx_q  <= pidx_d;
      pmag_q  <= pmag_d;
      midx_q  <= midx_d;
      max_q   <= max_d;
    end
  end

  assign peak_idx  = pidx_q;
  assign peak_mag  = pmag_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

endmodule
